// File: rtl/mem_port_arb_if.sv
// Bus bundle between the two memory requesters, the port arbiter and memory port 1.
// The slave modport is the arbiter's view. The master modport is the requester/memory side.
interface mem_port_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [17:0] req0_addr;
  logic [3:0]  req0_wen;
  logic [31:0] req0_wdata;
  logic        resp0_valid;
  logic [31:0] resp0_rdata;

  logic        req1_valid;
  logic        req1_ready;
  logic [17:0] req1_addr;
  logic [3:0]  req1_wen;
  logic [31:0] req1_wdata;
  logic        resp1_valid;
  logic [31:0] resp1_rdata;

  logic [17:0] mem_raddr;
  logic [17:0] mem_waddr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_addr, req0_wen, req0_wdata,
    output req0_ready, resp0_valid, resp0_rdata,
    input  req1_valid, req1_addr, req1_wen, req1_wdata,
    output req1_ready, resp1_valid, resp1_rdata,
    output mem_raddr, mem_waddr, mem_wen, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_addr, req0_wen, req0_wdata,
    input  req0_ready, resp0_valid, resp0_rdata,
    output req1_valid, req1_addr, req1_wen, req1_wdata,
    input  req1_ready, resp1_valid, resp1_rdata,
    input  mem_raddr, mem_waddr, mem_wen, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arb.sv
// Two-requester arbiter for memory data port 1. CPU (req0) wins by default.
// DMA (req1) is forced through after MAX_WAIT refusals. Read responses are tagged back to the issuer.
module mem_port_arb #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  mem_port_arb_if.slave  bus
);

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

  logic       g0, g1;
  logic       acc0, acc1, acc_read;
  logic [3:0] wait_cnt;
  tag_t       stage0, stage1;

  // Grant is purely a function of valids and the starvation counter, never of mem_rdata.
  assign g1   = bus.req1_valid && (!bus.req0_valid || wait_cnt == MaxWaitC);
  assign g0   = bus.req0_valid && !g1;
  assign acc0 = clk_en && g0;
  assign acc1 = clk_en && g1;

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;

  assign acc_read = (acc0 && bus.req0_wen == 4'b0) || (acc1 && bus.req1_wen == 4'b0);

  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    bus.mem_raddr = bus.req0_addr;
    bus.mem_waddr = bus.req0_addr;
    bus.mem_wdata = bus.req0_wdata;
    bus.mem_wen   = 4'b0;
    if (acc1) begin
      bus.mem_raddr = bus.req1_addr;
      bus.mem_waddr = bus.req1_addr;
      bus.mem_wdata = bus.req1_wdata;
      bus.mem_wen   = bus.req1_wen;
    end else if (acc0) begin
      bus.mem_wen   = bus.req0_wen;
    end
  end

  // NOTE: state registers use non-blocking assignments, so stage1 takes the old stage0 value.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage0   <= '0;
      stage1   <= '0;
      wait_cnt <= 4'd0;
    end else if (clk_en) begin
      stage0 <= '{v: acc_read, id: acc1};
      stage1 <= stage0;
      if (acc1 || !bus.req1_valid) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != MaxWaitC) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  assign bus.resp0_valid = stage1.v && !stage1.id;
  assign bus.resp1_valid = stage1.v &&  stage1.id;
  assign bus.resp0_rdata = bus.mem_rdata;
  assign bus.resp1_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb. It includes a byte-writable 64Kx32 memory model with a two-enabled-cycle read latency.
// Inputs change on the falling edge. Outputs are sampled 1ns after it, well away from the rising edge.
module tb_mem_port_arb;
  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  int   errors = 0;
  int   checks = 0;

  mem_port_arb_if bus ();

  mem_port_arb #(.MAX_WAIT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [65536];
  logic [31:0] rd_q1, rd_q2;

  always @(posedge clk) begin
    if (clk_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wen[b]) mem_arr[bus.mem_waddr[17:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      rd_q1 <= mem_arr[bus.mem_raddr[17:2]];
      rd_q2 <= rd_q1;
    end
  end
  assign bus.mem_rdata = rd_q2;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_wen = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_wen = '0; bus.req1_wdata = '0;
  endtask

  task automatic write0(input logic [17:0] a, input logic [31:0] d);
    bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_wen = 4'hF; bus.req0_wdata = d;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL wr0_ready: got %b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0; bus.req0_wen = 4'h0;
  endtask

  task automatic test_reset();
    idle();
    clk_en = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL rst_resp0: got %b want 0", bus.resp0_valid); end
    checks++; if (bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL rst_resp1: got %b want 0", bus.resp1_valid); end
    checks++; if (bus.mem_wen !== 4'h0) begin errors++; $display("FAIL rst_mem_wen: got %h want 0", bus.mem_wen); end
    checks++; if (dut.wait_cnt !== 4'd0) begin errors++; $display("FAIL rst_wait_cnt: got %0d want 0", dut.wait_cnt); end
  endtask

  task automatic test_single_read();
    write0(18'h40, 32'hDEADBEEF);
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h40; bus.req0_wen = 4'h0;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", bus.req0_ready); end
    checks++; if (bus.mem_raddr !== 18'h40) begin errors++; $display("FAIL rd_raddr: got %h want 40", bus.mem_raddr); end
    checks++; if (bus.mem_wen !== 4'h0) begin errors++; $display("FAIL rd_mem_wen: got %h want 0", bus.mem_wen); end
    tick();
    bus.req0_valid = 1'b0;
    checks++; if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL rd_early: got %b want 0", bus.resp0_valid); end
    tick();
    checks++; if (bus.resp0_valid !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b want 1", bus.resp0_valid); end
    checks++; if (bus.resp0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", bus.resp0_rdata); end
    checks++; if (bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL rd_resp1: got %b want 0", bus.resp1_valid); end
    tick();
    checks++; if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL rd_late: got %b want 0", bus.resp0_valid); end
  endtask

  task automatic test_byte_write();
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h40; bus.req1_wen = 4'b0100; bus.req1_wdata = 32'h00AB0000;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bw_ready: got %b want 1", bus.req1_ready); end
    checks++; if (bus.mem_wen !== 4'b0100) begin errors++; $display("FAIL bw_mem_wen: got %b want 0100", bus.mem_wen); end
    checks++; if (bus.mem_waddr !== 18'h40) begin errors++; $display("FAIL bw_waddr: got %h want 40", bus.mem_waddr); end
    checks++; if (bus.mem_wdata !== 32'h00AB0000) begin errors++; $display("FAIL bw_wdata: got %h want 00ab0000", bus.mem_wdata); end
    tick();
    bus.req1_wen = 4'h0;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bw_rd_ready: got %b want 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    checks++; if (bus.resp1_valid !== 1'b1) begin errors++; $display("FAIL bw_valid: got %b want 1", bus.resp1_valid); end
    checks++; if (bus.resp1_rdata !== 32'hDEABBEEF) begin errors++; $display("FAIL bw_data: got %h want deabbeef", bus.resp1_rdata); end
    checks++; if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL bw_resp0: got %b want 0", bus.resp0_valid); end
    tick();
  endtask

  task automatic test_contention();
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h100; bus.req0_wen = 4'h0;
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h200; bus.req1_wen = 4'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (bus.req1_ready !== (i % 5 == 4)) begin errors++; $display("FAIL ct_ready1[%0d]: got %b want %b", i, bus.req1_ready, (i % 5 == 4)); end
      checks++; if (bus.req0_ready !== (i % 5 != 4)) begin errors++; $display("FAIL ct_ready0[%0d]: got %b want %b", i, bus.req0_ready, (i % 5 != 4)); end
      checks++; if (dut.wait_cnt !== 4'(i % 5)) begin errors++; $display("FAIL ct_wait[%0d]: got %0d want %0d", i, dut.wait_cnt, i % 5); end
      tick();
    end
    idle();
    tick(); tick(); tick();
  endtask

  task automatic test_interleave();
    logic [31:0] exp_data [2];
    exp_data[0] = 32'h11112222;
    exp_data[1] = 32'h33334444;
    write0(18'h0, exp_data[0]);
    write0(18'h4, exp_data[1]);
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = (i < 6) && (i % 2 == 0); bus.req0_addr = 18'h0; bus.req0_wen = 4'h0;
      bus.req1_valid = (i < 6) && (i % 2 == 1); bus.req1_addr = 18'h4; bus.req1_wen = 4'h0;
      #1;
      if (i < 6) begin
        checks++; if ((i % 2 == 0 ? bus.req0_ready : bus.req1_ready) !== 1'b1) begin errors++; $display("FAIL il_ready[%0d]: got 0 want 1", i); end
      end
      if (i < 2) begin
        checks++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin errors++; $display("FAIL il_idle[%0d]: got %b want 00", i, {bus.resp0_valid, bus.resp1_valid}); end
      end else begin
        checks++; if ({bus.resp0_valid, bus.resp1_valid} !== (i % 2 == 0 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL il_valid[%0d]: got %b want %b", i, {bus.resp0_valid, bus.resp1_valid}, (i % 2 == 0 ? 2'b10 : 2'b01)); end
        checks++; if (bus.resp0_rdata !== exp_data[i % 2]) begin errors++; $display("FAIL il_data[%0d]: got %h want %h", i, bus.resp0_rdata, exp_data[i % 2]); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_stall();
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h40; bus.req0_wen = 4'h0;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL st_ready: got %b want 1", bus.req0_ready); end
    tick();
    idle();
    clk_en = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h40; bus.req1_wen = 4'hF; bus.req1_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL st_accept[%0d]: got %b want 0", i, bus.req1_ready); end
      checks++; if (bus.mem_wen !== 4'h0) begin errors++; $display("FAIL st_mem_wen[%0d]: got %h want 0", i, bus.mem_wen); end
      checks++; if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL st_resp[%0d]: got %b want 0", i, bus.resp0_valid); end
      tick();
    end
    idle();
    clk_en = 1'b1;
    #1;
    checks++; if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL st_early: got %b want 0", bus.resp0_valid); end
    tick();
    checks++; if (bus.resp0_valid !== 1'b1) begin errors++; $display("FAIL st_valid: got %b want 1", bus.resp0_valid); end
    checks++; if (bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL st_id: got %b want 0", bus.resp1_valid); end
    checks++; if (bus.resp0_rdata !== 32'hDEABBEEF) begin errors++; $display("FAIL st_data: got %h want deabbeef", bus.resp0_rdata); end
    clk_en = 1'b0;
    tick();
    checks++; if (bus.resp0_valid !== 1'b1) begin errors++; $display("FAIL st_hold_valid: got %b want 1", bus.resp0_valid); end
    checks++; if (bus.resp0_rdata !== 32'hDEABBEEF) begin errors++; $display("FAIL st_hold_data: got %h want deabbeef", bus.resp0_rdata); end
    clk_en = 1'b1;
    tick();
    checks++; if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL st_drop: got %b want 0", bus.resp0_valid); end
  endtask

  task automatic test_reset_midflight();
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h40; bus.req0_wen = 4'h0;
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h80; bus.req1_wen = 4'h0;
    tick();
    checks++; if (dut.wait_cnt !== 4'd1) begin errors++; $display("FAIL rm_wait_pre: got %0d want 1", dut.wait_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (dut.wait_cnt !== 4'd0) begin errors++; $display("FAIL rm_wait: got %0d want 0", dut.wait_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin errors++; $display("FAIL rm_resp[%0d]: got %b want 00", i, {bus.resp0_valid, bus.resp1_valid}); end
      tick();
    end
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h40; bus.req0_wen = 4'h0;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rm_rd_ready: got %b want 1", bus.req0_ready); end
    tick();
    idle();
    checks++; if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL rm_rd_early: got %b want 0", bus.resp0_valid); end
    tick();
    checks++; if (bus.resp0_valid !== 1'b1) begin errors++; $display("FAIL rm_rd_valid: got %b want 1", bus.resp0_valid); end
    checks++; if (bus.resp0_rdata !== 32'hDEABBEEF) begin errors++; $display("FAIL rm_rd_data: got %h want deabbeef", bus.resp0_rdata); end
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    clk_en = 1'b1;
    tick();
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_interleave();
    test_stall();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester arbiter for the shared data port (port 1) of the 64K×32 byte-writable main memory. It multiplexes a CPU data requester (req0) and a DMA/loader requester (req1) onto the single read/write address path, and tracks the memory's fixed two-enabled-cycle read latency. Each read response is routed back to the requester that issued it. It sits between the pipeline's memory stage, the DMA engine, and the memory's raddr1/rdata1/wen/waddr/wdata pins, and shares the memory's clk_en.

## Interface
- MAX_WAIT, 4: enabled cycles req1 may be refused while valid before it is forced to win (1..15).
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global stall; same signal that gates the memory.
- req0_valid  in  1  CPU request present.
- req0_ready  out  1  CPU request accepted this cycle.
- req0_addr  in  18  byte address; [1:0] passed through, ignored by memory.
- req0_wen  in  4  byte write enables; 0 = read.
- req0_wdata  in  32  write data.
- resp0_valid  out  1  read data for req0 on resp0_rdata.
- resp0_rdata  out  32  read data.
- req1_valid, req1_ready, req1_addr, req1_wen, req1_wdata, resp1_valid, resp1_rdata: same as req0, for DMA.
- mem_raddr  out  18  to memory raddr1.
- mem_waddr  out  18  to memory waddr.
- mem_wen  out  4  to memory wen.
- mem_wdata  out  32  to memory wdata.
- mem_rdata  in  32  from memory rdata1.

## Operation
- Grant (combinational): g1 = req1_valid && (!req0_valid || wait_cnt == MAX_WAIT); g0 = req0_valid && !g1.
- reqN_ready = clk_en && gN; an accept is ready && valid at a posedge.
- Granted request drives mem_raddr = mem_waddr = addr, mem_wen = wen, and mem_wdata = wdata. With no grant or clk_en=0: mem_wen = 0, addresses/wdata = req0 fields (don't-care).
- wait_cnt (4-bit). On each enabled edge:
  - cleared if req1 is accepted or req1_valid = 0;
  - else incremented when req1_valid && !g1, saturating at MAX_WAIT.
- Read tracking: 2-stage shift register of {v, id}. On each enabled edge, stage0 <= {accepted read (wen==0), granted id} and stage1 <= stage0.
- respN_valid = stage1.v && stage1.id == N. respN_rdata = mem_rdata for both N; data is meaningful only while valid.
- Writes produce no response; they are complete at the accepting edge.
- Same-edge read and write to one word is impossible (single grant). A read accepted the edge after a write to the same word returns the new data.
- clk_en = 0: wait_cnt and tag pipeline hold, no accepts, respN_valid held at its prior value (the memory output also holds).
- rst (takes priority over clk_en): stages v = 0, wait_cnt = 0.
  - Reads in flight at reset are dropped and never produce a response.
  - Outputs after reset: resp0_valid = resp1_valid = 0, mem_wen = 0 unless a grant is active.

## Timing
- Read accepted at enabled edge E0. Data is registered inside memory at E0, then at E1. respN_valid is high during the cycle after E1 (read latency 2 enabled cycles). Disabled cycles stretch this 1:1.
- Back-to-back accepts are allowed every enabled cycle. Responses return in issue order, one per cycle, and are interleavable between requesters.
- Requester must hold addr/wen/wdata stable while valid && !ready.
- Starvation bound: req1 is accepted within MAX_WAIT+1 enabled cycles of asserting valid.
- No combinational path from mem_rdata to any ready.

## Test plan
- Single read: preload word 0x10 (addr 0x40) = 0xDEADBEEF. req0 reads 0x40 -> req0_ready at E0, resp0_valid exactly in the cycle after E1, rdata 0xDEADBEEF, resp1_valid never high.
- Byte write then read: req1 writes wen=4'b0100, wdata=0x00AB0000 to addr 0x40, then reads it next cycle -> resp1_rdata = 0xDEABBEEF.
- Contention/starvation, MAX_WAIT=4: req0 and req1 both valid continuously -> req0 accepted 4 cycles, req1 on the 5th, pattern repeats; wait_cnt never exceeds 4.
- Interleaved reads: alternate req0 (addr 0x0) and req1 (addr 0x4) every cycle -> responses alternate resp0/resp1 with correct data, in issue order, no gaps.
- Stall: deassert clk_en for 3 cycles between E0 and E1 -> no accepts, no mem_wen, resp arrives 3 cycles later with correct data and id.
- Reset mid-flight: issue read, assert rst for 1 cycle at E1 -> no resp0_valid/resp1_valid afterwards; wait_cnt = 0; next read behaves as the single-read case.
